// File: rtl/lisa_qspi_arb_pkg.sv
// Shared definitions for the N-client QSPI arbiter.
//   arb_state_t : arbiter FSM states (IDLE, REQ, XFER)
//   clog2_min1  : index width for a client count, never less than 1 bit
package lisa_qspi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } arb_state_t;

  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/lisa_rr_pick.sv
// Combinational rotating-priority picker.
//   req     : request vector (already masked to the round-robin set)
//   ptr     : index with highest priority this round
//   win     : one-hot winner (zero when nothing requests)
//   win_idx : binary index of the winner
//   any     : at least one request present
module lisa_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  always_comb begin : scan
    int j;
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      // walk upward from ptr, wrapping at N
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any     = 1'b1;
        win[j]  = 1'b1;
        win_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/lisa_qspi_arbiter_n.sv
// N-client round-robin arbiter in front of a single QSPI controller.
// Client 0 (debugger) may optionally take absolute priority at arbitration.
// A granted client keeps the bus across transfers while it holds c_lock,
// and a watchdog aborts transfers that stall for tmo_limit cycles.
//   clk, rst            : clock, asynchronous active-high reset
//   c_addr .. c_lock    : per-client request fields, client i at slice i
//   c_rdata, c_ready,
//   c_xfer_done, c_err  : per-client responses, only the granted client sees them
//   grant               : registered one-hot grant
//   tmo_limit           : watchdog limit in cycles, 0 disables it
//   addr .. valid       : granted client's fields towards the controller
//   rdata, ready,
//   xfer_done           : controller responses
module lisa_qspi_arbiter_n
  import lisa_qspi_arb_pkg::*;
#(
  parameter int N_CLIENTS    = 4,
  parameter int CHIP_SELECTS = 2,
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 16,
  parameter int LEN_W        = 4,
  parameter int PRIO0_EN     = 1,
  parameter int TMO_W        = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_CLIENTS*ADDR_W-1:0]       c_addr,
  input  logic [N_CLIENTS*DATA_W-1:0]       c_wdata,
  input  logic [N_CLIENTS*2-1:0]            c_wstrb,
  input  logic [N_CLIENTS-1:0]              c_valid,
  input  logic [N_CLIENTS-1:0]              c_ready_ack,
  input  logic [N_CLIENTS*LEN_W-1:0]        c_xfer_len,
  input  logic [N_CLIENTS*CHIP_SELECTS-1:0] c_ce_ctrl,
  input  logic [N_CLIENTS-1:0]              c_lock,
  output logic [N_CLIENTS*DATA_W-1:0]       c_rdata,
  output logic [N_CLIENTS-1:0]              c_ready,
  output logic [N_CLIENTS-1:0]              c_xfer_done,
  output logic [N_CLIENTS-1:0]              c_err,
  output logic [N_CLIENTS-1:0]              grant,
  input  logic [TMO_W-1:0]                  tmo_limit,
  output logic [ADDR_W-1:0]                 addr,
  output logic [DATA_W-1:0]                 wdata,
  output logic [1:0]                        wstrb,
  output logic [LEN_W-1:0]                  xfer_len,
  output logic [CHIP_SELECTS-1:0]           ce_ctrl,
  output logic                              ready_ack,
  output logic                              valid,
  input  logic [DATA_W-1:0]                 rdata,
  input  logic                              ready,
  input  logic                              xfer_done
);

  localparam int IDX_W = clog2_min1(N_CLIENTS);
  localparam logic [IDX_W-1:0] RR_FIRST_IDX = IDX_W'((PRIO0_EN != 0) ? 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_CLIENTS - 1);
  // client 0 is excluded from the rotation when it has fixed priority
  localparam logic [N_CLIENTS-1:0] RR_MASK =
    (PRIO0_EN != 0) ? {{(N_CLIENTS-1){1'b1}}, 1'b0} : {N_CLIENTS{1'b1}};

  arb_state_t           state, state_nxt;
  logic [N_CLIENTS-1:0] grant_nxt;
  logic [IDX_W-1:0]     gidx, gidx_nxt;
  logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [TMO_W-1:0]     tmo_cnt, tmo_cnt_nxt;
  logic [N_CLIENTS-1:0] rr_req, pick_win;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 busy, g_valid, g_lock, done_evt, tmo_hit, take_prio0;
  logic                 finish, drop;

  assign rr_req     = c_valid & RR_MASK;
  assign busy       = (state == REQ) || (state == XFER);
  assign g_valid    = c_valid[gidx];
  assign g_lock     = c_lock[gidx];
  // in REQ a completion only counts when it arrives together with ready
  assign done_evt   = xfer_done && ((state == XFER) || ((state == REQ) && ready));
  // a real completion beats a watchdog hit in the same cycle
  assign tmo_hit    = busy && (tmo_limit != '0) && (tmo_cnt == tmo_limit) && !done_evt;
  assign take_prio0 = (PRIO0_EN != 0) && c_valid[0];

  lisa_rr_pick #(
    .N     (N_CLIENTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (rr_req),
    .ptr     (rr_ptr),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    gidx_nxt    = gidx;
    rr_ptr_nxt  = rr_ptr;
    tmo_cnt_nxt = tmo_cnt;
    finish      = 1'b0;
    drop        = 1'b0;

    // watchdog: restart on every word, saturate instead of wrapping
    if (busy) begin
      if (ready)                tmo_cnt_nxt = '0;
      else if (tmo_cnt != '1)   tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
    end

    unique case (state)
      IDLE: begin
        if (take_prio0) begin
          state_nxt   = REQ;
          grant_nxt   = N_CLIENTS'(1);
          gidx_nxt    = '0;
          tmo_cnt_nxt = '0;
        end else if (pick_any) begin
          state_nxt   = REQ;
          grant_nxt   = pick_win;
          gidx_nxt    = pick_idx;
          tmo_cnt_nxt = '0;
          rr_ptr_nxt  = (pick_idx == LAST_IDX) ? RR_FIRST_IDX : pick_idx + IDX_W'(1);
        end
      end
      REQ: begin
        if (tmo_hit)       drop      = 1'b1;
        else if (done_evt) finish    = 1'b1;
        else if (ready)    state_nxt = XFER;
        else if (!g_valid) drop      = 1'b1;
      end
      XFER: begin
        if (done_evt)     finish = 1'b1;
        else if (tmo_hit) drop   = 1'b1;
      end
      default: drop = 1'b1;
    endcase

    // locked owner with another request pending keeps the bus
    if (finish) begin
      if (g_lock && g_valid) begin
        state_nxt   = REQ;
        tmo_cnt_nxt = '0;
      end else begin
        drop = 1'b1;
      end
    end

    if (drop) begin
      state_nxt   = IDLE;
      grant_nxt   = '0;
      gidx_nxt    = '0;
      tmo_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      gidx    <= '0;
      rr_ptr  <= RR_FIRST_IDX;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      gidx    <= gidx_nxt;
      rr_ptr  <= rr_ptr_nxt;
      tmo_cnt <= tmo_cnt_nxt;
    end
  end

  // gidx rests at 0 without a grant, so the mux shows client 0 then
  assign valid     = (state == REQ) && g_valid;
  assign addr      = c_addr[int'(gidx)*ADDR_W +: ADDR_W];
  assign wdata     = c_wdata[int'(gidx)*DATA_W +: DATA_W];
  assign wstrb     = c_wstrb[int'(gidx)*2 +: 2];
  assign xfer_len  = c_xfer_len[int'(gidx)*LEN_W +: LEN_W];
  assign ce_ctrl   = c_ce_ctrl[int'(gidx)*CHIP_SELECTS +: CHIP_SELECTS];
  assign ready_ack = c_ready_ack[gidx];

  always_comb begin
    c_rdata = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (grant[i]) c_rdata[i*DATA_W +: DATA_W] = rdata;
    end
  end

  assign c_ready     = grant & {N_CLIENTS{ready}};
  assign c_xfer_done = grant & {N_CLIENTS{xfer_done | tmo_hit}};
  assign c_err       = grant & {N_CLIENTS{tmo_hit}};

endmodule
